breath_ramp: RTL and testbench
==============================

// Module: breath_ramp
// PURPOSE
//  Breathing-envelope generator: sequencer feeding the 4-bit PWM stage's duty input (sw).
//  Produces a triangle duty ramp 0->MAX->0 with dwell at both extremes.
//  Duty changes only at PWM-period boundaries, so the PWM never sees a mid-period duty change.
// PARAMETERS
//  DUTY_W      4  duty width; PWM period = 2**DUTY_W clk cycles; MAX = 2**DUTY_W-1
//  HOLD_STEPS  2  steps spent in each hold state; legal range 1..255
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  rst       in   1       synchronous, active-high reset
//  en        in   1       1 = run; 0 = freeze all counters and outputs
//  step_div  in   8       PWM periods per duty step, minus 1 (runtime, unregistered)
//  duty      out  DUTY_W  duty to PWM stage (registered)
//  duty_upd  out  1       1-cycle pulse, coincident with every duty change
//  peak      out  1       1-cycle pulse when duty reaches MAX
//  state     out  2       0 LO_HOLD, 1 RISE, 2 HI_HOLD, 3 FALL
// BEHAVIOUR
//  Reset (rst=1 at posedge, any state): duty=0, duty_upd=0, peak=0, state=LO_HOLD,
//   lvl=0, pcnt=0, scnt=0, hcnt=0. Reset has priority over en.
//  pcnt (DUTY_W bits) increments on every en=1 cycle; wraps MAX->0.
//   tick = en & (pcnt==MAX).
//  On tick: if scnt>=step_div then scnt<=0 and step=1, else scnt<=scnt+1.
//   The >= compare makes a step_div decrease below scnt fire on the next tick.
//  On step, per state:
//   LO_HOLD: hcnt++; if hcnt==HOLD_STEPS-1 -> hcnt=0, state RISE.
//   RISE:    lvl++; if new lvl==MAX -> state HI_HOLD.
//   HI_HOLD: as LO_HOLD, exits to FALL.
//   FALL:    lvl--; if new lvl==0 -> state LO_HOLD.
//  lvl never wraps: saturates at 0 and MAX.
//  duty, duty_upd, peak are registered from lvl/step: they update on the posedge after
//   the step edge (1-cycle latency). duty_upd=1 only in that cycle and only if lvl changed;
//   peak=1 only in that cycle, only when lvl became MAX.
//  en=0: pcnt/scnt/hcnt/lvl/state hold; duty holds; duty_upd=peak=0. Resuming en=1
//   continues from the frozen counts; no step is lost or duplicated.
//  Full cycle = (2*MAX + 2*HOLD_STEPS) steps * (step_div+1) * 2**DUTY_W en-cycles.
// CONFIGURATION
//  BREATH_GAMMA_EN defined: duty = (lvl*lvl + MAX) >> DUTY_W.
//   Intermediate is 2*DUTY_W bits wide. Maps 0->0 and MAX->MAX
//   (DUTY_W=4: lvl 8->4, lvl 15->15). Same 1-cycle latency.
//   duty_upd still pulses on every lvl change, even if the mapped duty is unchanged.
//  BREATH_GAMMA_EN undefined: duty = lvl (linear). No multiplier inferred.
// TESTING (DUTY_W=4, HOLD_STEPS=2 unless noted)
//  1 rst=1 for 3 clks with en=1, step_div=5 -> duty=0, duty_upd=0, peak=0, state=0 throughout.
//  2 en=1, step_div=0 from reset:
//    -> state=1 after 2nd tick (clk 32).
//    -> duty=1 with duty_upd pulse 1 clk after 3rd tick (clk 49).
//  3 step_div=0, run 544 clks:
//    -> duty goes 0..15..0 in unit steps, 30 duty_upd pulses, 1 peak pulse.
//    -> back to state=0, duty=0.
//  4 en=0 for 100 clks mid-RISE -> duty and state frozen, no pulses;
//    next duty_upd arrives exactly 100 clks later than in an unpaused run.
//  5 step_div=7, change to 0 when scnt=5 -> step fires on the next tick; every tick steps after.
//  6 rst=1 one cycle during FALL at duty=9 -> duty=0, state=0 next clk;
//    rst=1 for 1 clk with en=0 -> still resets.
//    With BREATH_GAMMA_EN: duty 4 at lvl 8, 15 at peak.

Source files
------------

// File: rtl/breath_ramp.sv
// breath_ramp: triangle breathing duty envelope for a PWM stage; define BREATH_GAMMA_EN for squared-law duty mapping
module breath_ramp #(
  parameter int DUTY_W = 4,
  parameter int HOLD_STEPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        step_div,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              peak,
  output logic [1:0]        state
);
  localparam logic [DUTY_W-1:0] MAX = '1;
  localparam logic [7:0] HLAST = 8'(HOLD_STEPS - 1);
  typedef enum logic [1:0] {LO_HOLD, RISE, HI_HOLD, FALL} st_t;
  st_t st, st_n;
  logic [DUTY_W-1:0] pcnt, lvl, lvl_n, map;
  logic [7:0] scnt, scnt_n, hcnt, hcnt_n;
  logic tick, step, chg, pk;
  assign tick = en & (pcnt == MAX);
  assign step = tick & (scnt >= step_div);
  assign state = st;
`ifdef BREATH_GAMMA_EN
  logic [2*DUTY_W-1:0] sq;
  assign sq = {{DUTY_W{1'b0}}, lvl} * {{DUTY_W{1'b0}}, lvl} + {{DUTY_W{1'b0}}, MAX};
  assign map = DUTY_W'(sq >> DUTY_W);
`else
  assign map = lvl;
`endif
  always_comb begin
    scnt_n = tick ? (step ? '0 : scnt + 8'd1) : scnt;
    lvl_n = lvl;
    st_n = st;
    hcnt_n = hcnt;
    if (step)
      case (st)
        LO_HOLD, HI_HOLD: begin
          hcnt_n = (hcnt == HLAST) ? '0 : hcnt + 8'd1;
          st_n = (hcnt != HLAST) ? st : (st == LO_HOLD) ? RISE : FALL;
        end
        RISE: begin
          lvl_n = (lvl == MAX) ? lvl : lvl + 1'b1;
          st_n = (lvl_n == MAX) ? HI_HOLD : RISE;
        end
        FALL: begin
          lvl_n = (lvl == '0) ? lvl : lvl - 1'b1;
          st_n = (lvl_n == '0) ? LO_HOLD : FALL;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= LO_HOLD;
      pcnt <= '0;
      scnt <= '0;
      hcnt <= '0;
      lvl <= '0;
      chg <= 1'b0;
      pk <= 1'b0;
      duty <= '0;
      duty_upd <= 1'b0;
      peak <= 1'b0;
    end else begin
      duty_upd <= en & chg;
      peak <= en & pk;
      if (en) begin
        pcnt <= pcnt + 1'b1;
        scnt <= scnt_n;
        hcnt <= hcnt_n;
        lvl <= lvl_n;
        st <= st_n;
        chg <= lvl_n != lvl;
        pk <= (lvl_n == MAX) && (lvl != MAX);
        duty <= map;
      end
    end
  end
endmodule

// File: tb/tb_breath_ramp.sv
// tb_breath_ramp: scoreboard bench for breath_ramp timing, pause, step_div change and reset
module tb_breath_ramp;
  logic clk = 0, rst = 1, en = 1;
  logic [7:0] step_div = 8'd5;
  logic [3:0] duty;
  logic duty_upd, peak;
  logic [1:0] state;
  int cyc = 0, checks = 0, errors = 0, npulse = 0, npeak = 0, p0, k0;
  typedef struct {int t; int d; int p;} ev_t;
  ev_t q[$];
  breath_ramp #(.DUTY_W(4), .HOLD_STEPS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .step_div(step_div),
    .duty(duty), .duty_upd(duty_upd), .peak(peak), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  function automatic int exp_duty(int l);
`ifdef BREATH_GAMMA_EN
    return (l * l + 15) >> 4;
`else
    return l;
`endif
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic push(int t, int d, int p);
    ev_t e;
    e.t = t;
    e.d = d;
    e.p = p;
    q.push_back(e);
  endtask
  task automatic push_breath(int after, int shift);
    for (int k = 3; k <= 17; k++)
      push(16 * k + 1 + ((16 * k + 1 > after) ? shift : 0), exp_duty(k - 2), int'(k == 17));
    for (int k = 20; k <= 34; k++)
      push(16 * k + 1 + ((16 * k + 1 > after) ? shift : 0), exp_duty(34 - k), 0);
  endtask
  task automatic mon();
    ev_t e;
    if (!rst && (duty_upd || peak)) begin
      if (duty_upd) npulse++;
      if (peak) npeak++;
      if (q.size() == 0) chk("spurious_upd", 1, 0);
      else begin
        e = q.pop_front();
        chk("upd_time", cyc, e.t);
        chk("upd_duty", duty, e.d);
        chk("upd_peak", peak, e.p);
        chk("upd_flag", duty_upd, 1);
      end
    end
  endtask
  task automatic run_to(int n);
    while (cyc < n) begin
      @(negedge clk);
      mon();
    end
  endtask
  task automatic do_reset(int n, logic e);
    rst = 1;
    en = e;
    repeat (n) @(negedge clk);
    rst = 0;
    en = 1;
    q.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_duty", duty, 0);
      chk("rst_upd", duty_upd, 0);
      chk("rst_peak", peak, 0);
      chk("rst_state", state, 0);
    end
    rst = 0;
    step_div = 0;
    push_breath(100000, 0);
    p0 = npulse;
    k0 = npeak;
    run_to(31);
    chk("state_pre_rise", state, 0);
    run_to(32);
    chk("state_rise", state, 1);
    run_to(560);
    chk("q_empty_full", q.size(), 0);
    chk("pulses_full", npulse - p0, 30);
    chk("peaks_full", npeak - k0, 1);
    chk("end_state", state, 0);
    chk("end_duty", duty, 0);
    do_reset(1, 1);
    push_breath(100, 100);
    p0 = npulse;
    run_to(100);
    en = 0;
    run_to(150);
    chk("pause_duty", duty, exp_duty(4));
    chk("pause_state", state, 1);
    run_to(200);
    en = 1;
    run_to(660);
    chk("q_empty_pause", q.size(), 0);
    chk("pulses_pause", npulse - p0, 30);
    do_reset(2, 1);
    step_div = 7;
    for (int i = 1; i <= 3; i++) push(113 + 16 * i, exp_duty(i), 0);
    run_to(81);
    step_div = 0;
    run_to(111);
    chk("div_state_hold", state, 0);
    run_to(112);
    chk("div_state_rise", state, 1);
    run_to(170);
    chk("q_empty_div", q.size(), 0);
    do_reset(1, 1);
    push_breath(100000, 0);
    run_to(405);
    chk("fall_duty", duty, exp_duty(9));
    chk("fall_state", state, 3);
    rst = 1;
    @(negedge clk);
    chk("midrst_duty", duty, 0);
    chk("midrst_state", state, 0);
    chk("midrst_upd", duty_upd, 0);
    chk("midrst_peak", peak, 0);
    rst = 0;
    q.delete();
    push(49, exp_duty(1), 0);
    push(65, exp_duty(2), 0);
    run_to(60);
    chk("rerun_duty", duty, exp_duty(1));
    chk("rerun_state", state, 1);
    rst = 1;
    en = 0;
    @(negedge clk);
    chk("enrst_duty", duty, 0);
    chk("enrst_state", state, 0);
    rst = 0;
    en = 1;
    q.delete();
    push(49, exp_duty(1), 0);
    push(65, exp_duty(2), 0);
    run_to(70);
    chk("q_empty_enrst", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
